des_key_sched_ctrl: RTL
=======================

# des_key_sched_ctrl

Sequencer for the DES key schedule. It loads a 64-bit key, applies PC-1, and drives two 28-bit rotators (C and D halves) through 16 rounds, choosing direction and shift amount per round. Each round key is emitted after PC-2 through a valid/ready handshake. It sits between the key register and the DES round datapath, and serves both encryption order (K1..K16) and decryption order (K16..K1).

## Interface
- No parameters; widths are fixed by DES (64-bit key, 28-bit halves, 48-bit round key).
- i_Clk  in  1  clock; all state updates on the rising edge
- i_Rst_n  in  1  synchronous reset, active-low
- i_Start  in  1  start request; sampled only in IDLE
- i_Key  in  64  DES key including parity bits; sampled with i_Start
- i_fDecrypt  in  1  1 = emit keys K16..K1; sampled with i_Start
- i_Abort  in  1  return to IDLE next cycle
- i_Ready  in  1  consumer accepts o_Key this cycle
- o_Valid  out  1  o_Key holds a valid round key
- o_Key  out  48  PC-2 round key; 0 when o_Valid=0
- o_Round  out  4  index of the emitted round, 0..15 (emission order)
- o_Last  out  1  o_Valid and o_Round==15
- o_Busy  out  1  FSM not in IDLE
- o_Err  out  1  one-cycle key-parity error pulse (see Configuration)

## Operation
- Shift schedule s(r), r=1..16: 1 for r in {1,2,9,16}; 2 otherwise.
- Encrypt:
  - On start, CD <= ROL(PC1(key), 1), giving CD1.
  - Each handshake: CD <= ROL(CD, s(r+1)).
  - Emitted key is PC2(CD).
- Decrypt:
  - On start, CD <= PC1(key). CD0 equals CD16, so the first key is K16 with no rotation.
  - On the handshake of emission index n (0..14), CD <= ROR(CD, 1) if n in {0,7,14}, else ROR(CD, 2).
- Both halves rotate with the same direction and amount. The rotator control is {fRight, f1bit}:
  - fRight = decrypt mode.
  - f1bit = 1 for a single-bit shift.
- FSM:
  - IDLE: on i_Start, load CD, clear the round counter, go to RUN.
  - RUN: o_Valid=1. On i_Ready, increment o_Round and update CD. A handshake at o_Round==15 goes to IDLE.
- Boundary rules:
  - i_Start while busy: ignored. The key and mode are latched only in IDLE.
  - i_Abort is highest priority. It beats a handshake and beats i_Start. It goes to IDLE and clears o_Valid next cycle.
  - i_Ready with o_Valid=0: no effect.
  - The round counter does not wrap. Leaving RUN after the 16th handshake is the only exit other than abort or reset.
  - Reset mid-run: all state is cleared at that edge. A partial sequence is never resumed.
- Reset values: o_Valid=0, o_Key=0, o_Round=0, o_Last=0, o_Busy=0, o_Err=0, CD=0, FSM=IDLE.

## Timing
- Start latency: i_Start high at edge t makes o_Valid high after edge t, with the first key.
- Throughput: one key per cycle while i_Ready stays high. 16 keys take 16 consecutive cycles.
- o_Key and o_Round are stable while o_Valid=1 and i_Ready=0.
- o_Busy falls in the cycle after the last handshake. A new i_Start is accepted in that same IDLE cycle, so a back-to-back gap is exactly one cycle.
- o_Key is combinational from the CD register (PC-2 wiring plus output mask). All control outputs are registered.

## Configuration
- DES_KS_PARITY_CHK_EN
  - Defined: at i_Start in IDLE, each key byte is checked for odd parity. On failure:
    - o_Err pulses high for one cycle.
    - The FSM stays in IDLE, o_Valid stays 0, and CD is not loaded.
  - Undefined: parity bits are ignored and o_Err is tied to 0.

## Structure
- The shared package des_pkg holds:
  - PC-1 and PC-2 index tables.
  - The shift-schedule constant (16-entry 1/2 vector).
  - The FSM state typedef.
- Sub-module rot28: the 28-bit rotator with {fRight, f1bit} control, covering ROL1/ROL2/ROR1/ROR2. It is instantiated twice, once for C and once for D.

## Test plan
- Encrypt, key 133457799BBCDFF1, i_Ready held 1 -> 16 consecutive valid cycles, first o_Key=1B02EFFC7072, o_Last with o_Key=CB3D8B0E17F5.
- Decrypt, same key -> first o_Key=CB3D8B0E17F5, last o_Key=1B02EFFC7072, sequence exactly the reverse of the encrypt sequence.
- Encrypt with i_Ready toggling 1010... -> same 16 keys in order, o_Key and o_Round held during stalls, total 32 cycles.
- i_Abort at o_Round=5 with i_Ready=1 -> no advance, o_Valid=0 and o_Busy=0 next cycle; i_Start asserted during the run before the abort is ignored.
- i_Rst_n=0 at o_Round=9 -> all outputs 0 next cycle; a restart yields K1 again.
- With DES_KS_PARITY_CHK_EN, key 133457799BBCDFF0 -> o_Err one-cycle pulse, o_Busy stays 0; with key ...F1 -> normal run, o_Err=0.

Source files
------------

// File: rtl/des_key_sched_ctrl_pkg.sv
// des_pkg: shared constants and helpers for the DES key-schedule sequencer.
// Holds the PC-1 / PC-2 index tables (DES bit numbering, bit 1 = MSB),
// the per-round shift schedule and the sequencer state type.
package des_pkg;

  // PC-1: 64-bit key (with parity) -> 56-bit C||D
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit C||D -> 48-bit round key
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit (r-1) set means round r uses a single-bit shift: rounds 1, 2, 9, 16.
  localparam logic [15:0] SHIFT1_SCHED = 16'h8103;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  function automatic logic [55:0] pc1_perm(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    end
    return r;
  endfunction

  // Each key byte must carry odd parity.
  function automatic logic key_parity_ok(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^key[6'(8 * b) +: 8]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_key_sched_ctrl_rot28.sv
// rot28: 28-bit circular rotator for one key-schedule half.
// Control {i_fRight, i_f1bit}: 00 ROL2, 01 ROL1, 10 ROR2, 11 ROR1.
module rot28 (
  input  logic [27:0] i_Din,
  input  logic        i_fRight,
  input  logic        i_f1bit,
  output logic [27:0] o_Dout
);

  // Select one of the four rotations.
  always_comb begin
    o_Dout = i_Din;
    case ({i_fRight, i_f1bit})
      2'b00:   o_Dout = {i_Din[25:0], i_Din[27:26]};
      2'b01:   o_Dout = {i_Din[26:0], i_Din[27]};
      2'b10:   o_Dout = {i_Din[1:0], i_Din[27:2]};
      2'b11:   o_Dout = {i_Din[0], i_Din[27:1]};
      default: o_Dout = i_Din;
    endcase
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: DES key-schedule sequencer.
// Loads a key, applies PC-1, steps the C/D halves through 16 rotations and
// presents each PC-2 round key on a valid/ready handshake, in encryption
// (K1..K16) or decryption (K16..K1) order.
// Optional build macro: DES_KS_PARITY_CHK_EN (odd-parity check of the key
// at start; a bad key pulses o_Err and the start is refused).
//
// state   | meaning
// --------+-----------------------------------------------------------
// KS_IDLE | waiting for i_Start; outputs masked, o_Busy = 0
// KS_RUN  | o_Key valid; each handshake rotates CD and bumps o_Round
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  input  logic [63:0] i_Key,
  input  logic        i_fDecrypt,
  input  logic        i_Abort,
  input  logic        i_Ready,
  output logic        o_Valid,
  output logic [47:0] o_Key,
  output logic [3:0]  o_Round,
  output logic        o_Last,
  output logic        o_Busy,
  output logic        o_Err
);

  ks_state_e   r_state, w_state_nxt;
  logic [55:0] r_cd, w_cd_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic        r_dec, w_dec_nxt;

  logic [55:0] w_pc1;
  logic [55:0] w_rot_in;
  logic [55:0] w_rot_out;
  logic        w_rot_right;
  logic        w_rot_1bit;
  logic        w_par_ok;

`ifdef DES_KS_PARITY_CHK_EN
  logic        r_err, w_err_nxt;
`endif

  assign w_pc1 = pc1_perm(i_Key);

`ifdef DES_KS_PARITY_CHK_EN
  assign w_par_ok = key_parity_ok(i_Key);
`else
  assign w_par_ok = 1'b1;
`endif

  // Both halves always rotate together with the same control.
  rot28 u_rot_c (
    .i_Din    (w_rot_in[55:28]),
    .i_fRight (w_rot_right),
    .i_f1bit  (w_rot_1bit),
    .o_Dout   (w_rot_out[55:28])
  );

  rot28 u_rot_d (
    .i_Din    (w_rot_in[27:0]),
    .i_fRight (w_rot_right),
    .i_f1bit  (w_rot_1bit),
    .o_Dout   (w_rot_out[27:0])
  );

  // Next-state, CD update and rotator control.
  // In IDLE the rotator is reused to form CD1 = ROL1(PC1(key)) for encrypt.
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_round_nxt = r_round;
    w_dec_nxt   = r_dec;
    w_rot_in    = r_cd;
    w_rot_right = r_dec;
    w_rot_1bit  = 1'b0;
`ifdef DES_KS_PARITY_CHK_EN
    w_err_nxt   = 1'b0;
`endif
    unique case (r_state)
      KS_IDLE: begin
        w_rot_in    = w_pc1;
        w_rot_right = 1'b0;
        w_rot_1bit  = 1'b1;
        if (!i_Abort && i_Start) begin
          if (w_par_ok) begin
            w_state_nxt = KS_RUN;
            w_round_nxt = 4'd0;
            w_dec_nxt   = i_fDecrypt;
            // CD0 == CD16, so decrypt starts unrotated at K16.
            w_cd_nxt    = i_fDecrypt ? w_pc1 : w_rot_out;
          end
`ifdef DES_KS_PARITY_CHK_EN
          else begin
            w_err_nxt = 1'b1;
          end
`endif
        end
      end
      KS_RUN: begin
        // Encrypt steps to round n+2 using s(n+2); decrypt undoes s(16-n).
        w_rot_1bit = r_dec ? SHIFT1_SCHED[~r_round] : SHIFT1_SCHED[r_round + 4'd1];
        if (i_Abort) begin
          w_state_nxt = KS_IDLE;
          w_round_nxt = 4'd0;
        end else if (i_Ready) begin
          w_cd_nxt = w_rot_out;
          if (r_round == 4'd15) begin
            w_state_nxt = KS_IDLE;
            w_round_nxt = 4'd0;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = KS_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state <= KS_IDLE;
      r_cd    <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_round <= w_round_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

`ifdef DES_KS_PARITY_CHK_EN
  // One-cycle parity error pulse.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign o_Err = r_err;
`else
  assign o_Err = 1'b0;
`endif

  assign o_Valid = (r_state == KS_RUN);
  assign o_Busy  = (r_state != KS_IDLE);
  assign o_Round = r_round;
  assign o_Last  = o_Valid && (r_round == 4'd15);
  assign o_Key   = o_Valid ? pc2_perm(r_cd) : 48'h0;

endmodule
